// File: rtl/game_phase_controller_if.sv
// Signal bundle between the game phase controller and its neighbours.
// slave  : the controller side (takes sync/key/game-logic levels, drives
//          phase, strobes and counters).
// master : the surrounding system (VGA generator, key, datapath).
interface game_phase_controller_if;
  logic       vsync;
  logic       start_button;
  logic       mario_hit;
  logic       level_complete;
  logic [2:0] phase;
  logic       frame_tick;
  logic       update_enable;
  logic       respawn;
  logic [3:0] lives;
  logic [9:0] seconds;

  modport master (
    output vsync, start_button, mario_hit, level_complete,
    input  phase, frame_tick, update_enable, respawn, lives, seconds
  );

  modport slave (
    input  vsync, start_button, mario_hit, level_complete,
    output phase, frame_tick, update_enable, respawn, lives, seconds
  );
endinterface

// File: rtl/game_phase_controller.sv
// Frame-synchronous game sequencer.
// Turns the active-low VGA vsync into a one-cycle frame tick, runs the
// TITLE/PLAY/DYING/WIN/OVER phase machine and owns the lives counter, the
// level countdown and the respawn pulse.
// Ports:
//   vga_clock  pixel clock, the only clock
//   reset      asynchronous active-low reset
//   gif        slave side of game_phase_controller_if
//              in : vsync, start_button (active-low), mario_hit, level_complete
//              out: phase, frame_tick, update_enable, respawn, lives, seconds
module game_phase_controller #(
  parameter int unsigned START_LIVES       = 3,
  parameter int unsigned LEVEL_SECONDS     = 300,
  parameter int unsigned FRAMES_PER_SECOND = 60,
  parameter int unsigned DYING_FRAMES      = 120
) (
  input  logic                     vga_clock,
  input  logic                     reset,
  game_phase_controller_if.slave   gif
);

  typedef enum logic [2:0] {
    TITLE = 3'd0,
    PLAY  = 3'd1,
    DYING = 3'd2,
    WIN   = 3'd3,
    OVER  = 3'd4
  } phase_t;

  localparam logic [3:0] LIVES_INIT   = 4'(START_LIVES);
  localparam logic [9:0] SECONDS_INIT = 10'(LEVEL_SECONDS);
  localparam logic [7:0] FPS_LAST     = 8'(FRAMES_PER_SECOND - 1);
  localparam logic [7:0] DYING_LAST   = 8'(DYING_FRAMES - 1);

  // Synchronisers plus one edge register each; all idle high.
  logic vsync_s1, vsync_s2, vsync_d;
  logic start_s1, start_s2, start_d;
  logic tick_next, press_next;
  logic start_press_q;

  logic       frame_tick_q, update_enable_q, respawn_q;
  phase_t     phase_q, phase_next;
  logic [3:0] lives_q, lives_next;
  logic [9:0] seconds_q, seconds_next;
  logic [7:0] frame_cnt_q, frame_cnt_next;
  logic       respawn_next;

  assign tick_next  = vsync_d & ~vsync_s2;
  assign press_next = start_d & ~start_s2;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      vsync_s1      <= 1'b1;
      vsync_s2      <= 1'b1;
      vsync_d       <= 1'b1;
      start_s1      <= 1'b1;
      start_s2      <= 1'b1;
      start_d       <= 1'b1;
      start_press_q <= 1'b0;
    end else begin
      vsync_s1      <= gif.vsync;
      vsync_s2      <= vsync_s1;
      vsync_d       <= vsync_s2;
      start_s1      <= gif.start_button;
      start_s2      <= start_s1;
      start_d       <= start_s2;
      start_press_q <= press_next;
    end
  end

  // Phase register and everything that changes with it.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      phase_q         <= TITLE;
      lives_q         <= LIVES_INIT;
      seconds_q       <= SECONDS_INIT;
      frame_cnt_q     <= '0;
      frame_tick_q    <= 1'b0;
      update_enable_q <= 1'b0;
      respawn_q       <= 1'b0;
    end else begin
      phase_q         <= phase_next;
      lives_q         <= lives_next;
      seconds_q       <= seconds_next;
      frame_cnt_q     <= frame_cnt_next;
      frame_tick_q    <= tick_next;
      // Registered alongside frame_tick so both rise in the same cycle.
      update_enable_q <= tick_next & (phase_q == PLAY);
      respawn_q       <= respawn_next;
    end
  end

  // frame_tick_q is the frame strobe the phase machine acts on.
  always_comb begin
    phase_next     = phase_q;
    lives_next     = lives_q;
    seconds_next   = seconds_q;
    frame_cnt_next = frame_cnt_q;
    respawn_next   = 1'b0;

    case (phase_q)
      TITLE: begin
        if (start_press_q) phase_next = PLAY;
      end
      PLAY: begin
        if (frame_tick_q) begin
          if (frame_cnt_q == FPS_LAST) begin
            frame_cnt_next = '0;
            if (seconds_q != '0) seconds_next = seconds_q - 10'd1;
          end else begin
            frame_cnt_next = frame_cnt_q + 8'd1;
          end
        end
        // Timeout uses the current count, so a hit in the cycle that zeroes
        // seconds leaves PLAY before the timeout can be seen: one life lost.
        if (gif.level_complete) begin
          phase_next = WIN;
        end else if (gif.mario_hit || (seconds_q == '0)) begin
          phase_next = DYING;
          if (lives_q != '0) lives_next = lives_q - 4'd1;
        end
      end
      DYING: begin
        if (frame_tick_q) begin
          if (frame_cnt_q == DYING_LAST) begin
            if (lives_q == '0) begin
              phase_next = OVER;
            end else begin
              phase_next   = PLAY;
              seconds_next = SECONDS_INIT;
            end
          end else begin
            frame_cnt_next = frame_cnt_q + 8'd1;
          end
        end
      end
      WIN, OVER: begin
        if (start_press_q) phase_next = TITLE;
      end
      default: phase_next = TITLE;
    endcase

    // Title holds the fresh-game values; loading on entry makes them visible
    // in the first TITLE cycle.
    if (phase_next == TITLE) begin
      lives_next   = LIVES_INIT;
      seconds_next = SECONDS_INIT;
    end

    // Respawn only happens on entry to PLAY, so a phase change covers both.
    if (phase_next != phase_q) frame_cnt_next = '0;

    respawn_next = (phase_next == PLAY) && (phase_q != PLAY);
  end

  assign gif.phase         = phase_q;
  assign gif.frame_tick    = frame_tick_q;
  assign gif.update_enable = update_enable_q;
  assign gif.respawn       = respawn_q;
  assign gif.lives         = lives_q;
  assign gif.seconds       = seconds_q;

endmodule

// File: tb/tb_game_phase_controller.sv
module tb_game_phase_controller;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_tick;
  int   n_ue;
  int   n_resp;
  int   t0, u0, r0;

  game_phase_controller_if gif();

  game_phase_controller #(
    .START_LIVES(2),
    .LEVEL_SECONDS(3),
    .FRAMES_PER_SECOND(2),
    .DYING_FRAMES(3)
  ) dut (
    .vga_clock(clk),
    .reset(rst_n),
    .gif(gif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_tick = 0;
    n_ue   = 0;
    n_resp = 0;
  end

  // Pulse counters, sampled well clear of the active edge.
  always @(posedge clk) begin
    #2;
    if (gif.frame_tick)    n_tick++;
    if (gif.update_enable) n_ue++;
    if (gif.respawn)       n_resp++;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk) gif.vsync = 1'b0;
    repeat (4) @(negedge clk);
    gif.vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_start();
    @(negedge clk) gif.start_button = 1'b0;
    repeat (6) @(negedge clk);
    gif.start_button = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    gif.vsync          = 1'b1;
    gif.start_button   = 1'b1;
    gif.mario_hit      = 1'b0;
    gif.level_complete = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_phase", gif.phase, 0);
    check("rst_lives", gif.lives, 2);
    check("rst_seconds", gif.seconds, 3);
    check("rst_tick", gif.frame_tick, 0);
    check("rst_ue", gif.update_enable, 0);
    check("rst_respawn", gif.respawn, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Four frames in TITLE: tick latency of three edges, no update strobe.
    t0 = n_tick; u0 = n_ue;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) gif.vsync = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("tick_early", gif.frame_tick, 0);
      @(posedge clk);
      #1 check("tick_latency", gif.frame_tick, 1);
      @(posedge clk);
      #1 check("tick_width", gif.frame_tick, 0);
      @(negedge clk) gif.vsync = 1'b1;
      repeat (4) @(negedge clk);
    end
    check("title_ticks", n_tick - t0, 4);
    check("title_ue", n_ue - u0, 0);
    check("title_phase", gif.phase, 0);
    check("title_lives", gif.lives, 2);
    check("title_seconds", gif.seconds, 3);

    // Held start key gives one press; countdown runs out after 6 ticks.
    r0 = n_resp;
    @(negedge clk) gif.start_button = 1'b0;
    repeat (10) @(negedge clk);
    check("start_respawn", n_resp - r0, 1);
    check("start_phase", gif.phase, 1);
    u0 = n_ue;
    frame();
    frame();
    check("play_sec_after2", gif.seconds, 2);
    repeat (4) frame();
    check("timeout_seconds", gif.seconds, 0);
    check("timeout_phase", gif.phase, 2);
    check("timeout_lives", gif.lives, 1);
    check("play_ue", n_ue - u0, 6);
    check("held_key_respawn", n_resp - r0, 1);
    gif.start_button = 1'b1;

    // Dying -> replay -> hit with last life -> game over -> title.
    r0 = n_resp;
    repeat (3) frame();
    check("revive_phase", gif.phase, 1);
    check("revive_respawn", n_resp - r0, 1);
    check("revive_seconds", gif.seconds, 3);
    @(negedge clk) gif.mario_hit = 1'b1;
    @(negedge clk) gif.mario_hit = 1'b0;
    repeat (2) @(negedge clk);
    check("hit_lives", gif.lives, 0);
    check("hit_phase", gif.phase, 2);
    r0 = n_resp;
    repeat (3) frame();
    check("over_phase", gif.phase, 4);
    check("over_no_respawn", n_resp - r0, 0);
    press_start();
    check("over_to_title", gif.phase, 0);
    check("newgame_lives", gif.lives, 2);

    // Simultaneous win and hit: win wins, no life lost.
    press_start();
    check("play2_phase", gif.phase, 1);
    @(negedge clk);
    gif.mario_hit = 1'b1;
    gif.level_complete = 1'b1;
    @(negedge clk);
    gif.mario_hit = 1'b0;
    gif.level_complete = 1'b0;
    repeat (2) @(negedge clk);
    check("win_phase", gif.phase, 3);
    check("win_lives", gif.lives, 2);
    press_start();
    check("win_to_title", gif.phase, 0);

    // Hit coinciding with the tick that takes seconds 1->0.
    press_start();
    check("play3_phase", gif.phase, 1);
    repeat (5) frame();
    check("pre_zero_seconds", gif.seconds, 1);
    @(negedge clk) gif.vsync = 1'b0;
    repeat (3) @(negedge clk);
    check("coinc_tick", gif.frame_tick, 1);
    gif.mario_hit = 1'b1;
    @(negedge clk) gif.mario_hit = 1'b0;
    gif.vsync = 1'b1;
    repeat (2) @(negedge clk);
    check("coinc_phase", gif.phase, 2);
    check("coinc_lives", gif.lives, 1);
    repeat (5) @(negedge clk);
    check("coinc_lives_hold", gif.lives, 1);
    check("coinc_phase_hold", gif.phase, 2);

    // Asynchronous reset mid-DYING, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("arst_phase", gif.phase, 0);
    check("arst_lives", gif.lives, 2);
    check("arst_seconds", gif.seconds, 3);
    check("arst_tick", gif.frame_tick, 0);
    check("arst_ue", gif.update_enable, 0);
    check("arst_respawn", gif.respawn, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_arst_phase", gif.phase, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
